// File: rtl/rv_pkg.sv
// Shared widths and types for the writeback path into the register file.
// XLEN: data width. REG_AW: register address width.
package rv_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 2 ** REG_AW;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_M = 1'b1
    } req_side_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry writeback hold slot with an age flag relative to its sibling slot.
// older=1 means the sibling slot holds the older entry.
module wb_hold_slot
    import rv_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    load,
    input  logic    drain,
    input  logic    other_valid,
    input  logic    other_drain,
    input  wb_req_t req_in,
    output logic    valid,
    output logic    older,
    output wb_req_t req
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            older <= 1'b0;
            // NOTE: the payload is reset too so rf_rd/rf_wdata never expose X after reset.
            req   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            // A sibling leaving on this same edge no longer counts as older.
            older <= other_valid && !other_drain;
            req   <= req_in;
        end else if (drain) begin
            valid <= 1'b0;
            older <= 1'b0;
        end else if (other_drain) begin
            older <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the ALU (A) and load unit (M) writeback slots onto the single
// register-file write port and exports the set of registers with pending writes.
module rf_write_arbiter
    import rv_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                a_valid,
    input  logic [REG_AW-1:0]   a_rd,
    input  logic [XLEN-1:0]     a_data,
    output logic                a_ready,
    input  logic                m_valid,
    input  logic [REG_AW-1:0]   m_rd,
    input  logic [XLEN-1:0]     m_data,
    output logic                m_ready,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_rd,
    output logic [XLEN-1:0]     rf_wdata,
    output logic [NUM_REGS-1:0] busy_mask
);

    logic      a_slot_valid, a_older, m_slot_valid, m_older;
    wb_req_t   a_req, m_req;
    logic      grant_a, grant_m, a_load, m_load;
    req_side_e rr_ptr;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant_a = 1'b0;
        grant_m = 1'b0;
        if (a_slot_valid && m_slot_valid) begin
            if (a_older != m_older) begin
                grant_a = m_older;
                grant_m = a_older;
            end else if (a_req.rd == m_req.rd) begin
                grant_m = 1'b1; // M is earlier in program order
            end else if (rr_ptr == REQ_A) begin
                grant_a = 1'b1;
            end else begin
                grant_m = 1'b1;
            end
        end else begin
            grant_a = a_slot_valid;
            grant_m = m_slot_valid;
        end
    end

    assign a_ready = !a_slot_valid || grant_a;
    assign m_ready = !m_slot_valid || grant_m;

    // Writes to x0 are acknowledged but dropped.
    assign a_load = a_valid && a_ready && (a_rd != '0);
    assign m_load = m_valid && m_ready && (m_rd != '0);

    wb_hold_slot u_slot_a (
        .clk         (clk),
        .reset       (reset),
        .load        (a_load),
        .drain       (grant_a),
        .other_valid (m_slot_valid),
        .other_drain (grant_m),
        .req_in      ('{rd: a_rd, data: a_data}),
        .valid       (a_slot_valid),
        .older       (a_older),
        .req         (a_req)
    );

    wb_hold_slot u_slot_m (
        .clk         (clk),
        .reset       (reset),
        .load        (m_load),
        .drain       (grant_m),
        .other_valid (a_slot_valid),
        .other_drain (grant_a),
        .req_in      ('{rd: m_rd, data: m_data}),
        .valid       (m_slot_valid),
        .older       (m_older),
        .req         (m_req)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= REQ_A;
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            if (a_slot_valid && m_slot_valid)
                rr_ptr <= grant_a ? REQ_M : REQ_A;
            rf_we <= grant_a || grant_m;
            if (grant_a) begin
                rf_rd    <= a_req.rd;
                rf_wdata <= a_req.data;
            end else if (grant_m) begin
                rf_rd    <= m_req.rd;
                rf_wdata <= m_req.data;
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        if (a_slot_valid) busy_mask[a_req.rd] = 1'b1;
        if (m_slot_valid) busy_mask[m_req.rd] = 1'b1;
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed stimulus pushes hand-ordered
// expected writes; a negedge monitor pops and compares each rf_we cycle.
module tb_rf_write_arbiter;
    import rv_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                a_valid, m_valid, a_ready, m_ready;
    logic [REG_AW-1:0]   a_rd, m_rd, rf_rd;
    logic [XLEN-1:0]     a_data, m_data, rf_wdata;
    logic                rf_we;
    logic [NUM_REGS-1:0] busy_mask;

    int      errors = 0;
    int      checks = 0;
    wb_req_t exp_q[$];
    logic [XLEN-1:0] rf_model [NUM_REGS];

    rf_write_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_rd      (a_rd),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .m_valid   (m_valid),
        .m_rd      (m_rd),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
        .busy_mask (busy_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int rd, input logic [XLEN-1:0] data);
        exp_q.push_back('{rd: REG_AW'(rd), data: data});
    endtask

    // Monitor: the register file samples on negedge.
    always @(negedge clk) begin
        if (reset && rf_we) begin
            rf_model[rf_rd] = rf_wdata;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got rd=%0d data=%h expected no write at %0t",
                         rf_rd, rf_wdata, $time);
            end else begin
                wb_req_t e;
                e = exp_q.pop_front();
                check("wr_rd", 64'(rf_rd), 64'(e.rd));
                check("wr_data", 64'(rf_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  ai, mi, guard;
        logic a_acc, m_acc, prev_both_low;

        reset = 1'b0;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        m_valid = 1'b0; m_rd = '0; m_data = '0;
        for (int r = 0; r < NUM_REGS; r++) rf_model[r] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 64'(rf_we), 0);
        check("rst_rd", 64'(rf_rd), 0);
        check("rst_wdata", 64'(rf_wdata), 0);
        check("rst_busy", 64'(busy_mask), 0);
        check("rst_ready", 64'({a_ready, m_ready}), 64'b11);
        reset = 1'b1;
        step();

        // Lone A write: busy during the hold cycle, written the next cycle.
        a_valid = 1'b1; a_rd = 5; a_data = 32'hDEAD_BEEF;
        push(5, 32'hDEAD_BEEF);
        step();
        a_valid = 1'b0;
        check("t2_busy_held", 64'(busy_mask), 64'(32'h0000_0020));
        check("t2_we_not_yet", 64'(rf_we), 0);
        step();
        check("t2_we", 64'(rf_we), 1);
        check("t2_rd", 64'(rf_rd), 5);
        check("t2_wdata", 64'(rf_wdata), 64'(32'hDEAD_BEEF));
        check("t2_busy_clear", 64'(busy_mask), 0);

        // Same-cycle writes to x7: M first, then A; A's value survives.
        a_valid = 1'b1; a_rd = 7; a_data = 32'h11;
        m_valid = 1'b1; m_rd = 7; m_data = 32'h22;
        push(7, 32'h22);
        push(7, 32'h11);
        step();
        a_valid = 1'b0; m_valid = 1'b0;
        check("t4_busy0", 64'(busy_mask), 64'(32'h0000_0080));
        step();
        check("t4_first_data", 64'(rf_wdata), 64'(32'h22));
        check("t4_busy1", 64'(busy_mask), 64'(32'h0000_0080));
        step();
        check("t4_second_data", 64'(rf_wdata), 64'(32'h11));
        check("t4_busy2", 64'(busy_mask), 0);
        @(negedge clk);
        #1;
        check("t4_rf_x7", 64'(rf_model[7]), 64'(32'h11));

        // Continuous contention: grants alternate A,M,A,M.
        for (int k = 1; k <= 8; k++) begin
            push(k, 32'hA000_0000 + k);
            push(8 + k, 32'hB000_0000 + 8 + k);
        end
        ai = 0; mi = 0; guard = 0; prev_both_low = 1'b0;
        step();
        while ((ai < 8 || mi < 8) && guard < 60) begin
            a_valid = (ai < 8); a_rd = REG_AW'(ai + 1); a_data = 32'hA000_0000 + ai + 1;
            m_valid = (mi < 8); m_rd = REG_AW'(mi + 9); m_data = 32'hB000_0000 + mi + 9;
            @(negedge clk);
            a_acc = a_valid && a_ready;
            m_acc = m_valid && m_ready;
            if (a_valid && m_valid) begin
                check("t3_ready_starve", 64'(prev_both_low && !a_ready && !m_ready), 0);
                prev_both_low = !a_ready && !m_ready;
            end
            step();
            if (a_acc) ai++;
            if (m_acc) mi++;
            guard++;
        end
        a_valid = 1'b0; m_valid = 1'b0;
        check("t3_accepted", 64'(ai + mi), 16);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        check("t3_drained", 64'(exp_q.size()), 0);

        // Writes to x0 are accepted and dropped.
        a_valid = 1'b1; a_rd = 0; a_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_ready", 64'(a_ready), 1);
            check("t5_we", 64'(rf_we), 0);
            check("t5_busy", 64'(busy_mask), 0);
            step();
        end
        a_valid = 1'b0;

        // Back-to-back A, one per cycle, M idle.
        for (int i = 0; i < 6; i++) begin
            a_valid = 1'b1; a_rd = REG_AW'(10 + i); a_data = 32'h6000_0000 + i;
            push(10 + i, 32'h6000_0000 + i);
            @(negedge clk);
            check("t6_ready", 64'(a_ready), 1);
            if (i >= 2) check("t6_we", 64'(rf_we), 1);
            step();
        end
        a_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t6_we_tail", 64'(rf_we), 1);
            step();
        end
        @(negedge clk);
        check("t6_we_idle", 64'(rf_we), 0);
        check("t6_drained", 64'(exp_q.size()), 0);

        // Reset mid-stream with both slots full: held writes are discarded.
        step();
        a_valid = 1'b1; a_rd = 3; a_data = 32'h33;
        m_valid = 1'b1; m_rd = 4; m_data = 32'h44;
        step();
        a_valid = 1'b0; m_valid = 1'b0;
        check("t1_busy_before", 64'(busy_mask), 64'(32'h0000_0018));
        #2;
        reset = 1'b0;
        #1;
        check("t1_we", 64'(rf_we), 0);
        check("t1_rd", 64'(rf_rd), 0);
        check("t1_wdata", 64'(rf_wdata), 0);
        check("t1_busy", 64'(busy_mask), 0);
        check("t1_ready", 64'({a_ready, m_ready}), 64'b11);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t1_no_write", 64'(rf_we), 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
